// File: rtl/sensor_pkg.sv
// ============================================================================
// Module      : sensor_pkg
// Description : Shared constants for the sensor packetizer (state codes,
//               default header byte, pad byte).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sensor_pkg;

    localparam int         STATE_W   = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_SEQ     = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] PAD_BYTE     = 8'h00;

endpackage

`default_nettype wire

// File: rtl/pkt_checksum.sv
// ============================================================================
// Module      : pkt_checksum
// Description : Clear/load/add accumulator, DATA_WIDTH wide, wraps mod 2^N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_checksum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_sum <= '0;
        end else if (load) begin
            r_sum <= din;
        end else if (add) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/sensor_packetizer.sv
// ============================================================================
// Module      : sensor_packetizer
// Description : Drains sensor bytes from a FIFO and frames them as
//               header / seq / payload / checksum packets on a valid/ready
//               byte stream. Optional macro PKT_TIMEOUT_EN pads starved
//               packets with zero bytes after TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_packetizer
    import sensor_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PAYLOAD_LEN = 16,
    parameter logic [DATA_WIDTH-1:0] HDR_BYTE    = DATA_WIDTH'(HDR_BYTE_DEF)
`ifdef PKT_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [7:0]            seq_num
);

    localparam int                CNT_W    = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_payload;
    logic [7:0]            r_seq;
    logic [DATA_WIDTH-1:0] w_csum;
    logic [DATA_WIDTH-1:0] w_csum_din;
    logic                  w_present;
    logic                  w_xfer;
    logic                  w_pad_now;

    // Valid is decoded from the state register alone, never from m_ready.
    assign w_present  = (r_state == S_HDR) || (r_state == S_SEQ) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_xfer     = w_present && m_ready;
    assign m_valid    = w_present;
    assign m_last     = (r_state == S_CSUM);
    assign busy       = (r_state != S_IDLE);
    assign seq_num    = r_seq;
    assign fifo_rd_en = (r_state == S_RD_REQ) && !fifo_empty && !w_pad_now;

`ifdef PKT_TIMEOUT_EN
    localparam int               ST_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ST_W-1:0]  TO_LAST = ST_W'(TIMEOUT_CYCLES - 1);

    logic [ST_W-1:0] r_starve;
    logic            r_pad;

    // Once starved, every remaining payload slot of this packet is padding.
    assign w_pad_now = (r_state == S_RD_REQ) &&
                       (r_pad || (fifo_empty && (r_starve == TO_LAST)));

    always_ff @(posedge clk) begin
        if (!rst_n || (r_state == S_IDLE)) begin
            r_starve <= '0;
            r_pad    <= 1'b0;
        end else if (fifo_rd_en) begin
            r_starve <= '0;
        end else if ((r_state == S_RD_REQ) && fifo_empty && !r_pad) begin
            if (r_starve == TO_LAST) begin
                r_pad <= 1'b1;
            end else begin
                r_starve <= r_starve + ST_W'(1);
            end
        end
    end
`else
    assign w_pad_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_data      = DATA_WIDTH'(PAD_BYTE);
        case (r_state)
            S_IDLE:    if (!fifo_empty) w_state_nxt = S_HDR;
            S_HDR: begin
                m_data = HDR_BYTE;
                if (w_xfer) w_state_nxt = S_SEQ;
            end
            S_SEQ: begin
                m_data = DATA_WIDTH'(r_seq);
                if (w_xfer) w_state_nxt = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (w_pad_now)        w_state_nxt = S_PAYLOAD;
                else if (!fifo_empty) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                m_data = r_payload;
                if (w_xfer) w_state_nxt = (r_cnt == LAST_IDX) ? S_CSUM : S_RD_REQ;
            end
            S_CSUM: begin
                m_data = w_csum;
                if (w_xfer) w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_payload <= '0;
            r_seq     <= '0;
        end else begin
            case (r_state)
                S_IDLE:    r_cnt <= '0;
                S_RD_REQ:  if (w_pad_now) r_payload <= DATA_WIDTH'(PAD_BYTE);
                S_RD_WAIT: r_payload <= fifo_rd_data;
                S_PAYLOAD: if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
                S_CSUM:    if (w_xfer) r_seq <= r_seq + 8'd1;
                default:   ;
            endcase
        end
    end

    // The checksum is seeded with the sequence number; the header is excluded.
    assign w_csum_din = (r_state == S_SEQ) ? DATA_WIDTH'(r_seq) : r_payload;

    pkt_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (r_state == S_IDLE),
        .load  (r_state == S_SEQ),
        .add   (w_xfer && (r_state == S_PAYLOAD)),
        .din   (w_csum_din),
        .sum   (w_csum)
    );

endmodule

`default_nettype wire
